calc_arbiter: RTL and testbench

- Shares one Calculator expression engine between NUM_REQ requesters, granting them round-robin.
- Captures the granted 256-bit ASCII expression and sequences the engine's rst/inp/finished interface.
- Returns the 32-bit result, tagged with the requester id, through a valid/ready response port.
- Sits between the host-side request sources and the single Calculator instance.

---
 rtl/calc_pkg.sv | 9 +
 rtl/calc_rr_arbiter.sv | 22 ++
 rtl/calc_arbiter.sv | 90 +++++++++
 tb/tb_calc_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, widths and ASCII constants for the calculator arbiter.
package calc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  localparam int EXPR_W = 256;
  localparam int ANS_W = 32;
  localparam int GUARD_CYCLES = 2;
  localparam logic [7:0] NL = 8'h0A;
  localparam logic [7:0] SP = 8'h20;
endpackage

// File: rtl/calc_rr_arbiter.sv
// calc_rr_arbiter: combinational round-robin pick, searching upward from ptr+1 modulo N.
module calc_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++)
      if (!any && req[(int'(ptr) + k) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
  end
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one Calculator engine with a tagged valid/ready result port.
// Define CALC_TIMEOUT_EN to bound each run to TIMEOUT cycles and report expiry on resp_err.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [EXPR_W*NUM_REQ-1:0]  req_expr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [ANS_W-1:0]           resp_ans,
  output logic                       resp_err,
  output logic                       busy,
  output logic                       calc_rst,
  output logic [EXPR_W-1:0]          calc_inp,
  input  logic [ANS_W-1:0]           calc_ans,
  input  logic                       calc_finished
);
  state_t state;
  logic [ID_W-1:0] ptr, g_idx, id_reg;
  logic [NUM_REQ-1:0] gnt;
  logic any, guard_done, done, expire;
  logic [EXPR_W-1:0] expr_reg;
  logic [1:0] g_cnt;

  calc_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(g_idx),
    .any(any)
  );

  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign busy = state != IDLE;
  assign calc_rst = state != RUN;
  assign calc_inp = expr_reg;
  assign resp_valid = state == RESP;
  assign resp_id = id_reg;
  // the engine may still show the previous run's finished flag for the first RUN cycles
  assign guard_done = g_cnt == 2'(GUARD_CYCLES);
  assign done = state == RUN && guard_done && calc_finished;

`ifdef CALC_TIMEOUT_EN
  logic [15:0] to_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= state == RUN ? to_cnt + 16'd1 : '0;
  assign expire = state == RUN && to_cnt == 16'(TIMEOUT - 1);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) g_cnt <= '0;
    else g_cnt <= state != RUN ? '0 : guard_done ? g_cnt : g_cnt + 2'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      expr_reg <= '0;
      id_reg <= '0;
      resp_ans <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          expr_reg <= req_expr[int'(g_idx)*EXPR_W +: EXPR_W];
          id_reg <= g_idx;
          ptr <= g_idx;
          state <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: if (done || expire) begin
          resp_ans <= done ? calc_ans : '0;
          resp_err <= !done;
          state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: random and directed traffic against a behavioural arbitration/engine model.
module tb_calc_arbiter;
  import calc_pkg::*;
  localparam int N = 4;
  localparam int TO = 16;

  typedef struct {
    logic [255:0] e;
    logic [31:0]  a;
    logic         err;
  } job_t;

  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [256*N-1:0] req_expr = '0;
  logic resp_valid, resp_ready = 0, resp_err, busy, calc_rst;
  logic [1:0] resp_id;
  logic [31:0] resp_ans, s_ans = 0;
  logic [255:0] calc_inp;
  logic s_fin = 0;

  calc_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_expr(req_expr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_ans(resp_ans),
    .resp_err(resp_err), .busy(busy), .calc_rst(calc_rst), .calc_inp(calc_inp),
    .calc_ans(s_ans), .calc_finished(s_fin)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  job_t jq[N][$];
  logic [255:0] tab_e[$];
  logic [31:0] tab_a[$];
  int log_id[$];
  logic [31:0] log_a[$];
  logic log_e[$];
  bit busy_m = 0, acc_v = 0, drop_en = 0, stall = 0;
  int last = N - 1, acc = 0, rr_mode = 1, lat_fix = 0, lat_cur = 1, s_cnt = 0;
  int exp_id;
  logic [31:0] exp_a;
  logic exp_err;
  logic [255:0] exp_e;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  function automatic logic [255:0] pad(input string s);
    logic [255:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[255-8*i -: 8] = s[i];
    r[255-8*s.len() -: 8] = NL;
    return r;
  endfunction

  function automatic logic [31:0] lookup(input logic [255:0] e);
    for (int i = 0; i < tab_e.size(); i++) if (tab_e[i] == e) return tab_a[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Engine stand-in: finished stays high (stale) until the first cycle out of reset.
  always @(posedge clk)
    if (calc_rst) begin
      s_cnt <= 0;
      lat_cur <= lat_fix != 0 ? lat_fix : int'($urandom_range(1, 6));
    end else begin
      s_cnt <= s_cnt + 1;
      if (s_cnt == 0) s_fin <= 0;
      if (!stall && s_cnt == lat_cur) begin
        s_fin <= 1;
        s_ans <= lookup(calc_inp);
      end
    end

  // Behavioural model: at most one job in flight, round-robin pick after the last grant.
  always @(negedge clk) begin
    bit b0;
    int g;
    if (rst) begin
      busy_m = 0;
      last = N - 1;
    end else begin
      b0 = busy_m;
      chk("busy", 32'(busy), 32'(b0));
      if (!b0 && req_valid != 0) begin
        g = -1;
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(last + k) % N]) g = (last + k) % N;
        chk("grant", 32'(req_ready), 32'(1 << g));
        busy_m = 1;
        exp_id = g;
        exp_a = jq[g][0].a;
        exp_err = jq[g][0].err;
        exp_e = jq[g][0].e;
        last = g;
        acc = g;
        acc_v = 1;
      end else chk("no_ready", 32'(req_ready), 0);
      if (b0 && !calc_rst) chk("calc_inp", 32'(calc_inp == exp_e), 1);
      if (resp_valid) begin
        chk("resp_unexpected", 32'(b0), 1);
        chk("resp_id", 32'(resp_id), 32'(exp_id));
        chk("resp_ans", resp_ans, exp_a);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_calc_rst", 32'(calc_rst), 1);
        if (resp_ready) begin
          log_id.push_back(int'(resp_id));
          log_a.push_back(resp_ans);
          log_e.push_back(resp_err);
          busy_m = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_v) begin
      void'(jq[acc].pop_front());
      acc_v = 0;
    end
    for (int i = 0; i < N; i++)
      if (jq[i].size() > 0 && (!drop_en || $urandom_range(0, 3) != 0)) begin
        req_valid[i] = 1;
        req_expr[i*256 +: 256] = jq[i][0].e;
      end else req_valid[i] = 0;
    resp_ready = rr_mode == 2 ? 1'($urandom_range(0, 1)) : rr_mode == 1;
  endtask

  task automatic push(input int i, input string s, input logic [31:0] a, input bit err = 0);
    job_t j;
    j.e = pad(s);
    j.a = a;
    j.err = err;
    jq[i].push_back(j);
    tab_e.push_back(j.e);
    tab_a.push_back(a);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (jq[i].size() > 0) return 1;
    return busy_m || busy;
  endfunction

  task automatic wait_idle(input int limit);
    int n = 0;
    while (pending() && n < limit) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(n < limit), 1);
  endtask

  task automatic clear_log();
    log_id.delete();
    log_a.delete();
    log_e.delete();
  endtask

  initial begin
    int n;
    logic [1:0] id0;
    logic [31:0] a0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_calc_rst", 32'(calc_rst), 1);
    chk("rst_calc_inp", 32'(calc_inp == '0), 1);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_ans", resp_ans, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;

    push(0, "8/2", 4); push(1, "(1+2)*3", 9); push(2, "10-4", 6); push(3, "6", 6);
    wait_idle(300);
    chk("cont_n", log_id.size(), 4);
    for (int i = 0; i < 4; i++) chk("cont_id", 32'(log_id[i]), 32'(i));
    chk("cont_a0", log_a[0], 4); chk("cont_a1", log_a[1], 9);
    chk("cont_a2", log_a[2], 6); chk("cont_a3", log_a[3], 6);

    clear_log();
    push(0, "1+2*3", 7);
    wait_idle(100);
    chk("single_n", log_id.size(), 1);
    chk("single_id", 32'(log_id[0]), 0);
    chk("single_ans", log_a[0], 7);
    chk("single_err", 32'(log_e[0]), 0);

    clear_log();
    rr_mode = 0;
    push(1, "2*2", 4); push(2, "9-1", 8);
    n = 0;
    while (!resp_valid && n < 100) begin step(); n++; end
    chk("bp_reach", 32'(resp_valid), 1);
    id0 = resp_id;
    a0 = resp_ans;
    chk("bp_id", 32'(id0), 1);
    chk("bp_ans", a0, 4);
    repeat (20) begin
      step();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_id_hold", 32'(resp_id), 32'(id0));
      chk("bp_ans_hold", resp_ans, a0);
      chk("bp_no_ready", 32'(req_ready), 0);
      chk("bp_calc_rst", 32'(calc_rst), 1);
    end
    rr_mode = 1;
    wait_idle(200);
    chk("bp_n", log_id.size(), 2);
    chk("bp_second", 32'(log_id[1]), 2);

    clear_log();
    push(1, "5*1", 5); push(3, "3+3", 6);
    wait_idle(200);
    chk("rot_n", log_id.size(), 2);
    chk("rot_first", 32'(log_id[0]), 3);
    chk("rot_second", 32'(log_id[1]), 1);

    clear_log();
    lat_fix = 20;
    push(0, "9*9", 81);
    n = 0;
    while (calc_rst && n < 50) begin step(); n++; end
    chk("ar_run_reach", 32'(calc_rst), 0);
    repeat (5) step();
    push(2, "4+4", 8);
    step();
    #2 rst = 1;
    #1;
    chk("ar_calc_rst", 32'(calc_rst), 1);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_resp_valid", 32'(resp_valid), 0);
    chk("ar_resp_id", 32'(resp_id), 0);
    chk("ar_resp_ans", resp_ans, 0);
    chk("ar_calc_inp", 32'(calc_inp == '0), 1);
    chk("ar_req_ready", 32'(req_ready), 0);
    lat_fix = 0;
    step();
    rst = 0;
    push(1, "7-2", 5);
    wait_idle(200);
    chk("ar_n", log_id.size(), 2);
    chk("ar_id0", 32'(log_id[0]), 2);
    chk("ar_a0", log_a[0], 8);
    chk("ar_id1", 32'(log_id[1]), 1);
    chk("ar_a1", log_a[1], 5);

    drop_en = 1;
    rr_mode = 2;
    for (int t = 0; t < 150; t++) begin
      int a = int'($urandom_range(0, 99)), b = int'($urandom_range(0, 99)), op = int'($urandom_range(0, 2));
      push(int'($urandom_range(0, N - 1)),
           $sformatf("%0d%s%0d", a, op == 0 ? "+" : op == 1 ? "-" : "*", b),
           32'(op == 0 ? a + b : op == 1 ? a - b : a * b));
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(8000);

`ifdef CALC_TIMEOUT_EN
    clear_log();
    drop_en = 0;
    rr_mode = 1;
    stall = 1;
    push(3, "1+1", 0, 1);
    n = 0;
    while (calc_rst && n < 50) begin step(); n++; end
    n = 0;
    while (!calc_rst && n < 100) begin step(); n++; end
    chk("to_run_cycles", n, TO);
    wait_idle(100);
    chk("to_n", log_id.size(), 1);
    chk("to_ans", log_a[0], 0);
    chk("to_err", 32'(log_e[0]), 1);
    stall = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
